axi4_mem_ctrl: RTL and testbench

//  AXI4 slave front-end that turns AXI4 INCR bursts into single-word accesses on the

---
 rtl/axi4_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_axi4_mem_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_ctrl.sv
// axi4_mem_ctrl: AXI4 INCR-burst slave driving a single-word 1024x32 memory port, one burst at a time.
// Optional GUARD_EN macro rejects out-of-range bursts with SLVERR and suppresses mem_en.
module axi4_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DEPTH          = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_MEM, RD_DATA} state_t;
    state_t state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic [7:0] cnt_q, cnt_d, ax_len;
    logic err_q, err_d, oob_q, oob_d, last_wr_q, last_wr_d;
    logic grant_w, grant_r, w_hs, last_beat, oob_in, unused_addr;
    logic [AXI_ADDR_WIDTH-1:0] ax_addr;

    // Round-robin: on a tie the channel not served last wins; reset favours write.
    assign grant_w     = AWVALID && (!ARVALID || !last_wr_q);
    assign grant_r     = ARVALID && !grant_w;
    assign ax_addr     = grant_w ? AWADDR : ARADDR;
    assign ax_len      = grant_w ? AWLEN : ARLEN;
    assign last_beat   = cnt_q == 8'd0;
    assign w_hs        = state_q == WR_DATA && WVALID;
    assign addr_inc    = addr_q == MEM_ADDR_WIDTH'(DEPTH - 1) ? '0 : addr_q + MEM_ADDR_WIDTH'(1);
    assign unused_addr = ^ax_addr;
`ifdef GUARD_EN
    logic [MEM_ADDR_WIDTH+8:0] end_word;
    assign end_word = (MEM_ADDR_WIDTH+9)'(ax_addr[LSB +: MEM_ADDR_WIDTH]) + (MEM_ADDR_WIDTH+9)'(ax_len);
    assign oob_in   = end_word >= (MEM_ADDR_WIDTH+9)'(DEPTH) || (ax_addr >> (LSB + MEM_ADDR_WIDTH)) != '0;
`else
    assign oob_in = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            oob_q     <= 1'b0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            oob_q     <= oob_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        oob_d     = oob_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: if (grant_w || grant_r) begin
                state_d   = grant_w ? WR_DATA : RD_MEM;
                addr_d    = ax_addr[LSB +: MEM_ADDR_WIDTH];
                cnt_d     = ax_len;
                err_d     = oob_in;
                oob_d     = oob_in;
                last_wr_d = grant_w;
            end
            // Beat count ends the burst; a misplaced WLAST only flags the response.
            WR_DATA: if (WVALID) begin
                err_d   = err_q || (WLAST != last_beat);
                addr_d  = addr_inc;
                cnt_d   = cnt_q - 8'd1;
                state_d = last_beat ? WR_RESP : WR_DATA;
            end
            WR_RESP: state_d = BREADY ? IDLE : WR_RESP;
            RD_MEM:  state_d = RD_DATA;
            RD_DATA: if (RREADY) begin
                state_d = last_beat ? IDLE : RD_MEM;
                addr_d  = addr_inc;
                cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        AWREADY   = state_q == IDLE && grant_w;
        ARREADY   = state_q == IDLE && grant_r;
        WREADY    = state_q == WR_DATA;
        BVALID    = state_q == WR_RESP;
        BRESP     = BVALID && err_q ? 2'b10 : 2'b00;
        mem_we    = w_hs && !oob_q;
        mem_en    = mem_we || (state_q == RD_MEM && !oob_q);
        mem_addr  = addr_q;
        mem_wdata = mem_we ? WDATA : '0;
        RVALID    = state_q == RD_DATA;
        RLAST     = RVALID && last_beat;
        RDATA     = RVALID && !oob_q ? mem_rdata : '0;
        RRESP     = RVALID && oob_q ? 2'b10 : 2'b00;
    end
endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// tb_axi4_mem_ctrl: directed vector table plus hand-written burst sequences for axi4_mem_ctrl.
// Expectations for the wrap/guard case follow the GUARD_EN macro.
module tb_axi4_mem_ctrl;
    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic [15:0] AWADDR = '0, ARADDR = '0;
    logic [7:0]  AWLEN = '0, ARLEN = '0;
    logic        AWVALID = 1'b0, WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic [31:0] WDATA = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID, mem_en, mem_we;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem [1024];
    int          checks = 0, errors = 0, en_cnt = 0;

    axi4_mem_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    // Behavioural 1024x32 memory with a registered read port.
    always @(posedge ACLK) begin
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [31:0] d0;
        int          word;
        logic [1:0]  resp;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0; WLAST = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    // Starts at 1 time unit after a rising edge; ends the same way.
    task automatic do_write(input logic [15:0] a, input logic [7:0] len, input logic [31:0] d0,
                            input int bad, input bit exp_en, input int word, output logic [1:0] resp);
        AWADDR = a; AWLEN = len; AWVALID = 1'b1;
        #1 chk("awready", 32'(AWREADY), 1);
        @(posedge ACLK); #1 AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = d0 + i;
            WLAST = bad >= 0 ? i == bad : i == int'(len);
            WVALID = 1'b1;
            #1 chk("wready", 32'(WREADY), 1);
            chk("wr_mem_en", 32'(mem_en), 32'(exp_en));
            chk("wr_mem_we", 32'(mem_we), 32'(exp_en));
            if (exp_en) begin
                chk("wr_mem_addr", 32'(mem_addr), (word + i) % 1024);
                chk("wr_mem_wdata", mem_wdata, d0 + i);
            end
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        #1 chk("bvalid", 32'(BVALID), 1);
        resp = BRESP;
        @(posedge ACLK); #1 BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] len, input bit toggle,
                           input logic [31:0] d0, input int word, input bit oob);
        ARADDR = a; ARLEN = len; ARVALID = 1'b1;
        #1 chk("arready", 32'(ARREADY), 1);
        @(posedge ACLK); #1 ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            chk("rd_mem_rvalid", 32'(RVALID), 0);
            chk("rd_mem_en", 32'(mem_en), 32'(!oob));
            if (!oob) chk("rd_mem_addr", 32'(mem_addr), (word + i) % 1024);
            @(posedge ACLK); #1;
            if (toggle && i % 2 == 0) begin
                RREADY = 1'b0;
                #1 chk("rvalid_stall", 32'(RVALID), 1);
                @(posedge ACLK); #1;
            end
            RREADY = 1'b1;
            #1 chk("rvalid", 32'(RVALID), 1);
            chk("rdata", RDATA, oob ? 32'h0 : d0 + i);
            chk("rlast", 32'(RLAST), 32'(i == int'(len)));
            chk("rresp", 32'(RRESP), oob ? 2 : 0);
            @(posedge ACLK); #1 RREADY = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] s0, s1;
        int          e0;
        vecs[0] = '{1'b1, 16'h0010, 8'd0, 32'hDEADBEEF, 4,    2'b00};
        vecs[1] = '{1'b0, 16'h0010, 8'd0, 32'hDEADBEEF, 4,    2'b00};
        vecs[2] = '{1'b1, 16'h0020, 8'd3, 32'h1,        8,    2'b00};
        vecs[3] = '{1'b0, 16'h0020, 8'd3, 32'h1,        8,    2'b00};
        vecs[4] = '{1'b1, 16'h0103, 8'd1, 32'h100,      64,   2'b00};
        vecs[5] = '{1'b0, 16'h0100, 8'd1, 32'h100,      64,   2'b00};
        vecs[6] = '{1'b1, 16'h0FF0, 8'd2, 32'hA000,     1020, 2'b00};
        vecs[7] = '{1'b0, 16'h0FF2, 8'd2, 32'hA000,     1020, 2'b00};

        do_reset();
        chk("reset_ctrl", 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, mem_en, mem_we, BRESP, RRESP}), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_mem_wdata", mem_wdata, 0);

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].wr) begin
                do_write(vecs[k].addr, vecs[k].len, vecs[k].d0, -1, 1'b1, vecs[k].word, resp);
                chk("vec_bresp", 32'(resp), 32'(vecs[k].resp));
            end else
                do_read(vecs[k].addr, vecs[k].len, vecs[k].len != 0, vecs[k].d0, vecs[k].word, 1'b0);
        end

        // Simultaneous AW/AR: write wins after reset, then read wins.
        do_reset();
        AWADDR = 16'h0040; AWLEN = 8'd0; AWVALID = 1'b1;
        ARADDR = 16'h0010; ARLEN = 8'd0; ARVALID = 1'b1;
        #1 chk("rr1_awready", 32'(AWREADY), 1);
        chk("rr1_arready", 32'(ARREADY), 0);
        @(posedge ACLK); #1 AWVALID = 1'b0;
        WDATA = 32'h33; WLAST = 1'b1; WVALID = 1'b1;
        #1 chk("rr_busy_arready", 32'(ARREADY), 0);
        @(posedge ACLK); #1 WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        #1 chk("rr_bvalid", 32'(BVALID), 1);
        @(posedge ACLK); #1 BREADY = 1'b0; AWVALID = 1'b1;
        #1 chk("rr2_arready", 32'(ARREADY), 1);
        chk("rr2_awready", 32'(AWREADY), 0);
        @(posedge ACLK); #1 ARVALID = 1'b0;
        @(posedge ACLK); #1 RREADY = 1'b1;
        #1 chk("rr_rdata", RDATA, 32'hDEADBEEF);
        @(posedge ACLK); #1 RREADY = 1'b0;
        #1 chk("rr3_awready", 32'(AWREADY), 1);
        AWVALID = 1'b0;
        chk("rr_mem16", mem[16], 32'h33);
        @(posedge ACLK); #1;

        // Burst crossing the top of memory.
        s0 = mem[1023]; s1 = mem[0]; e0 = en_cnt;
`ifdef GUARD_EN
        do_write(16'h0FFC, 8'd1, 32'hAAAA0001, -1, 1'b0, 1023, resp);
        chk("guard_bresp", 32'(resp), 2);
        chk("guard_no_en", en_cnt, e0);
        chk("guard_mem1023", mem[1023], s0);
        chk("guard_mem0", mem[0], s1);
        do_read(16'h0FFC, 8'd1, 1'b0, 32'h0, 1023, 1'b1);
        do_write(16'h1000, 8'd0, 32'h5, -1, 1'b0, 0, resp);
        chk("guard_high_bresp", 32'(resp), 2);
`else
        do_write(16'h0FFC, 8'd1, 32'hAAAA0001, -1, 1'b1, 1023, resp);
        chk("wrap_bresp", 32'(resp), 0);
        chk("wrap_mem1023", mem[1023], 32'hAAAA0001);
        chk("wrap_mem0", mem[0], 32'hAAAA0002);
        do_read(16'h0FFC, 8'd1, 1'b0, 32'hAAAA0001, 1023, 1'b0);
`endif

        // Reset in the middle of a read burst.
        ARADDR = 16'h0020; ARLEN = 8'd3; ARVALID = 1'b1;
        #1 chk("mid_arready", 32'(ARREADY), 1);
        @(posedge ACLK); #1 ARVALID = 1'b0;
        @(posedge ACLK); #1 RREADY = 1'b1;
        #1 chk("mid_beat1", RDATA, 32'h1);
        @(posedge ACLK); #1 RREADY = 1'b0;
        @(posedge ACLK); #1;
        #1 chk("mid_beat2_rvalid", 32'(RVALID), 1);
        ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        #1 chk("mid_rvalid_cleared", 32'(RVALID), 0);
        chk("mid_mem_en", 32'(mem_en), 0);
        ARVALID = 1'b1;
        #1 chk("mid_arready_after", 32'(ARREADY), 1);
        ARVALID = 1'b0;
        @(posedge ACLK); #1;

        // Early WLAST on a 3-beat write: all beats land, response is SLVERR.
        do_write(16'h0200, 8'd2, 32'h600, 1, 1'b1, 128, resp);
        chk("wlast_bresp", 32'(resp), 2);
        chk("wlast_mem128", mem[128], 32'h600);
        chk("wlast_mem130", mem[130], 32'h602);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
